serial_mult_arbiter: RTL and testbench

//   Shares one 16x16 shift-add serial multiplier engine among N_REQ requesters.

---
 rtl/serial_mult_arbiter.sv | 172 +++++++++++++++++
 tb/tb_serial_mult_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mult_arbiter.sv
// -----------------------------------------------------------------------------
// serial_mult_arbiter
//   Shares one WIDTH x WIDTH shift-add multiplier among N_REQ requesters.
//   A round-robin arbiter picks a pending request while idle and captures its
//   operands. The engine then adds one shifted partial product per cycle for
//   exactly WIDTH cycles. The product and the owner's index are returned on a
//   valid/ready response port. Only one multiply is in flight at a time.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req_valid     per-requester request valid            [N_REQ]
//   req_a         multiplicands, lane i at [i*WIDTH +: WIDTH]
//   req_b         multipliers, same packing as req_a
//   req_ready     one-hot grant (combinational, only while idle)
//   resp_valid    product available
//   resp_ready    consumer accepts the product
//   resp_product  unsigned a*b                           [2*WIDTH]
//   resp_id       index of the requester owning resp_product
//   busy          high while a multiply runs or waits for acceptance
// -----------------------------------------------------------------------------
module serial_mult_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int ID_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [2*WIDTH-1:0]       resp_product,
    output logic [ID_W-1:0]          resp_id,
    output logic                     busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    // Pointer starts at the last index so requester 0 wins first after reset.
    localparam logic [ID_W-1:0]  RR_INIT  = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [ID_W-1:0]    rr_ptr_r;
    logic [ID_W-1:0]    id_r;
    logic [WIDTH-1:0]   a_reg_r;
    logic [WIDTH-1:0]   b_reg_r;
    logic [PW-1:0]      acc_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               grant_found_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic [WIDTH-1:0]   a_sel_s;
    logic [WIDTH-1:0]   b_sel_s;
    logic [PW-1:0]      addend_s;
    logic [PW-1:0]      acc_next_s;

    // Round-robin search: first valid requester after rr_ptr, wrapping.
    always_comb begin
        int idx_v;
        idx_v         = 0;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx_v = (int'(rr_ptr_r) + k) % N_REQ;
            if (!grant_found_s && req_valid[idx_v]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = ID_W'(idx_v);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Operand mux for the lane that would be granted this cycle.
    always_comb begin
        a_sel_s = req_a[int'(grant_idx_s) * WIDTH +: WIDTH];
        b_sel_s = req_b[int'(grant_idx_s) * WIDTH +: WIDTH];
    end

    // Grant is visible only while idle; the engine never accepts otherwise.
    always_comb begin
        req_ready = '0;
        if (state_r == IDLE && grant_found_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Shift-add step: the current multiplier LSB selects a*2^cnt.
    always_comb begin
        if (b_reg_r[0]) begin
            addend_s = {{WIDTH{1'b0}}, a_reg_r} << cnt_r;
        end else begin
            addend_s = '0;
        end
        acc_next_s = acc_r + addend_s;
    end

    // Control FSM, datapath registers and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            rr_ptr_r     <= RR_INIT;
            id_r         <= '0;
            a_reg_r      <= '0;
            b_reg_r      <= '0;
            acc_r        <= '0;
            cnt_r        <= '0;
            resp_valid   <= 1'b0;
            resp_product <= '0;
            resp_id      <= '0;
            busy         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_found_s) begin
                        a_reg_r  <= a_sel_s;
                        b_reg_r  <= b_sel_s;
                        id_r     <= grant_idx_s;
                        rr_ptr_r <= grant_idx_s;
                        acc_r    <= '0;
                        cnt_r    <= '0;
                        busy     <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    acc_r   <= acc_next_s;
                    b_reg_r <= b_reg_r >> 1;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    // Fixed-length run: no early exit even if b_reg empties.
                    if (cnt_r == CNT_LAST) begin
                        resp_product <= acc_next_s;
                        resp_id      <= id_r;
                        resp_valid   <= 1'b1;
                        state_r      <= DONE;
                    end else begin
                        state_r      <= RUN;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        state_r    <= DONE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mult_arbiter.sv
module tb_serial_mult_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_product;
    logic [1:0]  resp_id;
    logic        busy;

    int n_cmp;
    int n_bad;

    serial_mult_arbiter #(.N_REQ(4), .WIDTH(16), .ID_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_product (resp_product),
        .resp_id      (resp_id),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int lane, input logic [15:0] a, input logic [15:0] b);
        req_a[lane*16 +: 16] = a;
        req_b[lane*16 +: 16] = b;
    endtask

    // Issue one request set, check grant, latency, result and handshake.
    task automatic run_op(input string name, input logic [3:0] mask, input int exp_g,
                          input logic [31:0] exp_p, input bit hold, input int stall);
        int cycles;
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0001 << exp_g;
        req_valid = mask;
        #1;
        n_cmp++;
        if (req_ready !== exp_rdy) begin
            n_bad++; $display("FAIL %s grant: req_ready=%b expected %b", name, req_ready, exp_rdy);
        end
        tick();
        if (!hold) req_valid = 4'b0000;
        n_cmp++;
        if (busy !== 1'b1 || req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL %s run: busy=%b req_ready=%b expected 1/0000", name, busy, req_ready);
        end
        cycles = 0;
        while (resp_valid !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        n_cmp++;
        if (cycles != 16) begin
            n_bad++; $display("FAIL %s latency: %0d cycles expected 16", name, cycles);
        end
        n_cmp++;
        if (resp_product !== exp_p || resp_id !== 2'(exp_g)) begin
            n_bad++; $display("FAIL %s result: product=%h id=%0d expected %h id=%0d",
                              name, resp_product, resp_id, exp_p, exp_g);
        end
        for (int s = 0; s < stall; s++) begin
            tick();
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_product !== exp_p || resp_id !== 2'(exp_g)
                || req_ready !== 4'b0000 || busy !== 1'b1) begin
                n_bad++; $display("FAIL %s hold[%0d]: valid=%b product=%h id=%0d rdy=%b expected 1 %h %0d 0000",
                                  name, s, resp_valid, resp_product, resp_id, req_ready, exp_p, exp_g);
            end
        end
        resp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000 || resp_valid !== 1'b1) begin
            n_bad++; $display("FAIL %s handshake: req_ready=%b valid=%b expected 0000/1", name, req_ready, resp_valid);
        end
        tick();
        resp_ready = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL %s accept: valid=%b busy=%b expected 0/0", name, resp_valid, busy);
        end
    endtask

    task automatic do_reset();
        req_valid  = 4'b0000;
        resp_ready = 1'b0;
        rst_n      = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        req_a = 64'h0;
        req_b = 64'h0;
        do_reset();
        n_cmp++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_product !== 32'h0
            || resp_id !== 2'd0 || req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL reset: valid=%b busy=%b product=%h id=%0d rdy=%b expected all zero",
                              resp_valid, busy, resp_product, resp_id, req_ready);
        end
    endtask

    task automatic test_single();
        set_lane(1, 16'd3, 16'd5);
        run_op("single", 4'b0010, 1, 32'h0000000F, 1'b0, 0);
    endtask

    task automatic test_extremes();
        set_lane(0, 16'hFFFF, 16'hFFFF);
        run_op("ext_max", 4'b0001, 0, 32'hFFFE0001, 1'b0, 0);
        set_lane(0, 16'h1234, 16'h0000);
        run_op("ext_zero", 4'b0001, 0, 32'h00000000, 1'b0, 0);
        set_lane(0, 16'h8000, 16'h8000);
        run_op("ext_msb", 4'b0001, 0, 32'h40000000, 1'b0, 0);
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) set_lane(i, 16'(i + 1), 16'd100);
        run_op("rr_0", 4'b1111, 0, 32'd100, 1'b1, 0);
        run_op("rr_1", 4'b1111, 1, 32'd200, 1'b1, 0);
        run_op("rr_2", 4'b1111, 2, 32'd300, 1'b1, 0);
        run_op("rr_3", 4'b1111, 3, 32'd400, 1'b1, 0);
        run_op("rr_0b", 4'b0101, 0, 32'd100, 1'b1, 0);
        run_op("rr_2b", 4'b0101, 2, 32'd300, 1'b1, 0);
        run_op("rr_0c", 4'b0101, 0, 32'd100, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        set_lane(1, 16'h00FF, 16'h0101);
        // Other lanes stay valid so a leaked grant during DONE would show.
        run_op("backpressure", 4'b1110, 1, 32'h0000FFFF, 1'b1, 10);
        req_valid = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_run();
        int seen;
        set_lane(2, 16'hABCD, 16'h1357);
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        for (int i = 0; i < 8; i++) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_product !== 32'h0
            || resp_id !== 2'd0 || req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL mid_reset: valid=%b busy=%b product=%h id=%0d rdy=%b expected all zero",
                              resp_valid, busy, resp_product, resp_id, req_ready);
        end
        tick();
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (resp_valid === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++; $display("FAIL stale_resp: %0d active cycles expected 0", seen);
        end
        set_lane(3, 16'd7, 16'd9);
        run_op("after_reset", 4'b1000, 3, 32'd63, 1'b0, 0);
    endtask

    task automatic test_withdrawal();
        int seen;
        set_lane(0, 16'd11, 16'd13);
        set_lane(2, 16'd5, 16'd5);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        seen = 0;
        while (resp_valid !== 1'b1 && seen < 40) begin
            tick();
            seen++;
        end
        n_cmp++;
        if (resp_product !== 32'd143 || resp_id !== 2'd0) begin
            n_bad++; $display("FAIL withdraw_result: product=%h id=%0d expected 0000008f id=0",
                              resp_product, resp_id);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (resp_valid === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++; $display("FAIL withdraw_grant: %0d active cycles expected 0", seen);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        req_valid  = 4'b0000;
        resp_ready = 1'b0;
        req_a      = 64'h0;
        req_b      = 64'h0;
        test_reset();
        test_single();
        test_extremes();
        test_round_robin();
        test_backpressure();
        test_reset_mid_run();
        test_withdrawal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
